// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared state encoding, default frame geometry and address-width helper for snn_stream_io
package snn_pkg;

  localparam int SNN_DATA_W  = 32;
  localparam int SNN_OPT_W   = 2;
  localparam int SNN_IMG_LEN = 48;
  localparam int SNN_KER_LEN = 27;
  localparam int SNN_WGT_LEN = 4;
  localparam int SNN_OUT_LEN = 4;

  typedef enum logic [1:0] {
    SNN_IDLE = 2'd0,
    SNN_LOAD = 2'd1,
    SNN_CORE = 2'd2,
    SNN_EMIT = 2'd3
  } snn_state_e;

  // A one-entry buffer still gets a 1-bit address so no port collapses to zero width.
  function automatic int snn_addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snn_word_buf.sv
// rtl/snn_word_buf.sv - depth x width register array, one synchronous write port, one combinational read port
module snn_word_buf
  import snn_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 32,
  localparam int AW    = snn_addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we && (int'(i_waddr) < DEPTH)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Non-power-of-two depths leave unused address codes; those read back as zero.
  assign o_rdata = (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/snn_stream_io.sv
// rtl/snn_stream_io.sv - frame capture, core handshake and result burst replay for the Siamese datapath
// Optional sticky protocol checker and o_proto_err port enabled by defining SNN_IO_PROTO_CHK_EN.
module snn_stream_io
  import snn_pkg::*;
#(
  parameter int DATA_W  = SNN_DATA_W,
  parameter int OPT_W   = SNN_OPT_W,
  parameter int IMG_LEN = SNN_IMG_LEN,
  parameter int KER_LEN = SNN_KER_LEN,
  parameter int WGT_LEN = SNN_WGT_LEN,
  parameter int OUT_LEN = SNN_OUT_LEN
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_in_valid,
  input  logic [DATA_W-1:0]              i_img,
  input  logic [DATA_W-1:0]              i_kernel,
  input  logic [DATA_W-1:0]              i_weight,
  input  logic [OPT_W-1:0]               i_opt,
  output logic                           o_core_start,
  output logic [OPT_W-1:0]               o_core_opt,
  input  logic [snn_addr_w(IMG_LEN)-1:0] i_img_raddr,
  output logic [DATA_W-1:0]              o_img_rdata,
  input  logic [snn_addr_w(KER_LEN)-1:0] i_ker_raddr,
  output logic [DATA_W-1:0]              o_ker_rdata,
  input  logic [snn_addr_w(WGT_LEN)-1:0] i_wgt_raddr,
  output logic [DATA_W-1:0]              o_wgt_rdata,
  input  logic                           i_res_valid,
  input  logic [DATA_W-1:0]              i_res_data,
  output logic                           o_out_valid,
  output logic [DATA_W-1:0]              o_out
`ifdef SNN_IO_PROTO_CHK_EN
  ,
  output logic                           o_proto_err
`endif
);

  localparam int IAW = snn_addr_w(IMG_LEN);
  localparam int KAW = snn_addr_w(KER_LEN);
  localparam int WAW = snn_addr_w(WGT_LEN);
  localparam int OAW = snn_addr_w(OUT_LEN);

  localparam logic [1:0] S_IDLE = SNN_IDLE;
  localparam logic [1:0] S_LOAD = SNN_LOAD;
  localparam logic [1:0] S_CORE = SNN_CORE;
  localparam logic [1:0] S_EMIT = SNN_EMIT;

  logic [1:0]        r_state;
  logic [IAW-1:0]    r_beat;
  logic [OAW-1:0]    r_res_idx;
  logic [OAW-1:0]    r_emit_idx;
  logic              r_core_start;
  logic [OPT_W-1:0]  r_opt_pend;
  logic [OPT_W-1:0]  r_core_opt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out;

  logic              w_accept;
  logic [IAW-1:0]    w_beat_idx;
  logic              w_ker_we;
  logic              w_wgt_we;
  logic              w_last_beat;
  logic              w_res_we;
  logic              w_last_res;
  logic              w_emit_last;
  logic [OAW-1:0]    w_emit_next;
  logic [OAW-1:0]    w_res_raddr;
  logic [DATA_W-1:0] w_res_rdata;

  assign w_accept    = i_in_valid && ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_beat_idx  = (r_state == S_LOAD) ? r_beat : '0;
  assign w_ker_we    = w_accept && (int'(w_beat_idx) < KER_LEN);
  assign w_wgt_we    = w_accept && (int'(w_beat_idx) < WGT_LEN);
  assign w_last_beat = w_accept && (int'(w_beat_idx) == IMG_LEN - 1);
  assign w_res_we    = i_res_valid && (r_state == S_CORE);
  assign w_last_res  = w_res_we && (int'(r_res_idx) == OUT_LEN - 1);
  assign w_emit_last = (int'(r_emit_idx) == OUT_LEN - 1);
  assign w_emit_next = r_emit_idx + 1'b1;
  // Prefetch the word that will be on o_out after the next edge.
  assign w_res_raddr = (r_state == S_EMIT) ? w_emit_next : '0;

  snn_word_buf #(.DEPTH(IMG_LEN), .WIDTH(DATA_W)) u_img_buf (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (w_beat_idx),
    .i_wdata (i_img),
    .i_raddr (i_img_raddr),
    .o_rdata (o_img_rdata)
  );

  snn_word_buf #(.DEPTH(KER_LEN), .WIDTH(DATA_W)) u_ker_buf (
    .clk     (clk),
    .i_we    (w_ker_we),
    .i_waddr (w_beat_idx[KAW-1:0]),
    .i_wdata (i_kernel),
    .i_raddr (i_ker_raddr),
    .o_rdata (o_ker_rdata)
  );

  snn_word_buf #(.DEPTH(WGT_LEN), .WIDTH(DATA_W)) u_wgt_buf (
    .clk     (clk),
    .i_we    (w_wgt_we),
    .i_waddr (w_beat_idx[WAW-1:0]),
    .i_wdata (i_weight),
    .i_raddr (i_wgt_raddr),
    .o_rdata (o_wgt_rdata)
  );

  snn_word_buf #(.DEPTH(OUT_LEN), .WIDTH(DATA_W)) u_res_buf (
    .clk     (clk),
    .i_we    (w_res_we),
    .i_waddr (r_res_idx),
    .i_wdata (i_res_data),
    .i_raddr (w_res_raddr),
    .o_rdata (w_res_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      r_res_idx    <= '0;
      r_emit_idx   <= '0;
      r_core_start <= 1'b0;
      r_opt_pend   <= '0;
      r_core_opt   <= '0;
      r_out_valid  <= 1'b0;
      r_out        <= '0;
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_opt_pend <= i_opt;
            if (w_last_beat) begin
              r_state      <= S_CORE;
              r_core_start <= 1'b1;
              r_core_opt   <= i_opt;
              r_res_idx    <= '0;
            end else begin
              r_state <= S_LOAD;
              r_beat  <= IAW'(1);
            end
          end
        end
        S_LOAD: begin
          if (!i_in_valid) begin
            r_state <= S_IDLE;
          end else if (w_last_beat) begin
            r_state      <= S_CORE;
            r_core_start <= 1'b1;
            r_core_opt   <= r_opt_pend;
            r_res_idx    <= '0;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        S_CORE: begin
          if (w_last_res) begin
            r_state     <= S_EMIT;
            r_out_valid <= 1'b1;
            // With a single result word the buffer write lands on this same edge.
            r_out       <= (OUT_LEN == 1) ? i_res_data : w_res_rdata;
            r_emit_idx  <= '0;
          end else if (w_res_we) begin
            r_res_idx <= r_res_idx + 1'b1;
          end
        end
        S_EMIT: begin
          if (w_emit_last) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out       <= '0;
          end else begin
            r_out      <= w_res_rdata;
            r_emit_idx <= w_emit_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_core_start = r_core_start;
  assign o_core_opt   = r_core_opt;
  assign o_out_valid  = r_out_valid;
  assign o_out        = r_out;

`ifdef SNN_IO_PROTO_CHK_EN
  logic r_proto_err;
  logic w_short_frame;
  logic w_busy_in;
  logic w_stray_res;

  assign w_short_frame = (r_state == S_LOAD) && !i_in_valid;
  assign w_busy_in     = i_in_valid && ((r_state == S_CORE) || (r_state == S_EMIT));
  assign w_stray_res   = i_res_valid && (r_state != S_CORE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_proto_err <= 1'b0;
    end else if (w_short_frame || w_busy_in || w_stray_res) begin
      r_proto_err <= 1'b1;
    end
  end

  assign o_proto_err = r_proto_err;
`endif

endmodule

// File: tb/tb_snn_stream_io.sv
// tb/tb_snn_stream_io.sv - scoreboard bench: default-geometry instance plus a small 8/8/1/1 x16 instance
module tb_snn_stream_io;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_in_valid;
  logic [31:0] a_img, a_ker, a_wgt;
  logic [1:0]  a_opt;
  logic        a_core_start;
  logic [1:0]  a_core_opt;
  logic [5:0]  a_img_raddr;
  logic [31:0] a_img_rdata;
  logic [4:0]  a_ker_raddr;
  logic [31:0] a_ker_rdata;
  logic [1:0]  a_wgt_raddr;
  logic [31:0] a_wgt_rdata;
  logic        a_res_valid;
  logic [31:0] a_res_data;
  logic        a_out_valid;
  logic [31:0] a_out;

  logic        b_in_valid;
  logic [15:0] b_img, b_ker, b_wgt;
  logic [1:0]  b_opt;
  logic        b_core_start;
  logic [1:0]  b_core_opt;
  logic [2:0]  b_img_raddr;
  logic [15:0] b_img_rdata;
  logic [2:0]  b_ker_raddr;
  logic [15:0] b_ker_rdata;
  logic [0:0]  b_wgt_raddr;
  logic [15:0] b_wgt_rdata;
  logic        b_res_valid;
  logic [15:0] b_res_data;
  logic        b_out_valid;
  logic [15:0] b_out;

`ifdef SNN_IO_PROTO_CHK_EN
  logic a_proto_err;
  logic b_proto_err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb_a[$];
  logic [15:0] sb_b[$];
  logic [31:0] exp_words [4];

  snn_stream_io u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in_valid   (a_in_valid),
    .i_img        (a_img),
    .i_kernel     (a_ker),
    .i_weight     (a_wgt),
    .i_opt        (a_opt),
    .o_core_start (a_core_start),
    .o_core_opt   (a_core_opt),
    .i_img_raddr  (a_img_raddr),
    .o_img_rdata  (a_img_rdata),
    .i_ker_raddr  (a_ker_raddr),
    .o_ker_rdata  (a_ker_rdata),
    .i_wgt_raddr  (a_wgt_raddr),
    .o_wgt_rdata  (a_wgt_rdata),
    .i_res_valid  (a_res_valid),
    .i_res_data   (a_res_data),
    .o_out_valid  (a_out_valid),
    .o_out        (a_out)
`ifdef SNN_IO_PROTO_CHK_EN
    ,
    .o_proto_err  (a_proto_err)
`endif
  );

  snn_stream_io #(
    .DATA_W (16), .OPT_W (2), .IMG_LEN (8), .KER_LEN (8), .WGT_LEN (1), .OUT_LEN (1)
  ) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in_valid   (b_in_valid),
    .i_img        (b_img),
    .i_kernel     (b_ker),
    .i_weight     (b_wgt),
    .i_opt        (b_opt),
    .o_core_start (b_core_start),
    .o_core_opt   (b_core_opt),
    .i_img_raddr  (b_img_raddr),
    .o_img_rdata  (b_img_rdata),
    .i_ker_raddr  (b_ker_raddr),
    .o_ker_rdata  (b_ker_rdata),
    .i_wgt_raddr  (b_wgt_raddr),
    .o_wgt_rdata  (b_wgt_rdata),
    .i_res_valid  (b_res_valid),
    .i_res_data   (b_res_data),
    .o_out_valid  (b_out_valid),
    .o_out        (b_out)
`ifdef SNN_IO_PROTO_CHK_EN
    ,
    .o_proto_err  (b_proto_err)
`endif
  );

  // Caller sits at posedge+1; returns at posedge+1 just after the edge that sampled the last beat.
  task automatic drive_frame(input int nbeats, input int base, input logic [1:0] opt, output int early);
    early = 0;
    for (int k = 0; k < nbeats; k++) begin
      a_in_valid = 1'b1;
      a_img      = 32'(base + k);
      a_ker      = 32'(base + 100 + k);
      a_wgt      = 32'(base + 200 + k);
      a_opt      = (k == 0) ? opt : ~opt;
      @(posedge clk); #1;
      if (k < nbeats - 1 && a_core_start) early++;
    end
    a_in_valid = 1'b0;
    a_img      = '0;
    a_ker      = '0;
    a_wgt      = '0;
  endtask

  task automatic run_results(input int gap, input int inject, input int rst_at);
    int waited;
    logic [31:0] e;
    for (int j = 0; j < 4; j++) begin
      a_res_valid = 1'b1;
      a_res_data  = exp_words[j];
      sb_a.push_back(exp_words[j]);
      @(posedge clk); #1;
      a_res_valid = 1'b0;
      if (j < 3) begin
        checks++;
        if (a_out_valid !== 1'b0 || a_out !== 32'h0) begin
          failures++;
          $display("FAIL out_idle_before j=%0d got valid=%0b out=%h exp valid=0 out=0", j, a_out_valid, a_out);
        end
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    waited = 0;
    while (!a_out_valid && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (waited != 0) begin
      failures++;
      $display("FAIL out_latency got=%0d extra cycles exp=0", waited);
    end
    for (int j = 0; j < 4; j++) begin
      e = (sb_a.size() > 0) ? sb_a.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (a_out_valid !== 1'b1 || a_out !== e) begin
        failures++;
        $display("FAIL out_word j=%0d got valid=%0b out=%h exp valid=1 out=%h", j, a_out_valid, a_out, e);
      end
      if (rst_at == j) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out !== 32'h0 || a_core_start !== 1'b0) begin
          failures++;
          $display("FAIL async_reset got valid=%0b out=%h start=%0b exp 0/0/0", a_out_valid, a_out, a_core_start);
        end
        sb_a.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (inject != 0 && j == 1) begin
        a_in_valid = 1'b1;
        a_img      = 32'hDEAD;
        a_ker      = 32'hBEEF;
        a_wgt      = 32'hCAFE;
        a_opt      = 2'd3;
      end
      if (inject != 0 && j == 3) a_in_valid = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (a_out_valid !== 1'b0 || a_out !== 32'h0) begin
      failures++;
      $display("FAIL out_idle_after got valid=%0b out=%h exp valid=0 out=0", a_out_valid, a_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_img = '0; a_ker = '0; a_wgt = '0; a_opt = '0;
    a_img_raddr = '0; a_ker_raddr = '0; a_wgt_raddr = '0; a_res_valid = 1'b0; a_res_data = '0;
    b_in_valid = 1'b0; b_img = '0; b_ker = '0; b_wgt = '0; b_opt = '0;
    b_img_raddr = '0; b_ker_raddr = '0; b_wgt_raddr = '0; b_res_valid = 1'b0; b_res_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out !== 32'h0 || a_core_start !== 1'b0 || a_core_opt !== 2'd0) begin
      failures++;
      $display("FAIL reset_a got valid=%0b out=%h start=%0b opt=%0d exp all 0", a_out_valid, a_out, a_core_start, a_core_opt);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_out !== 16'h0 || b_core_start !== 1'b0 || b_core_opt !== 2'd0) begin
      failures++;
      $display("FAIL reset_b got valid=%0b out=%h start=%0b opt=%0d exp all 0", b_out_valid, b_out, b_core_start, b_core_opt);
    end
`ifdef SNN_IO_PROTO_CHK_EN
    checks++;
    if (a_proto_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_proto got=%0b exp=0", a_proto_err);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_frame();
    int early;
    drive_frame(48, 0, 2'd2, early);
    checks++;
    if (early != 0 || a_core_start !== 1'b1) begin
      failures++;
      $display("FAIL core_start_timing got early=%0d start=%0b exp early=0 start=1", early, a_core_start);
    end
    a_img_raddr = 6'd5; a_ker_raddr = 5'd26; a_wgt_raddr = 2'd3;
    #1;
    checks++;
    if (a_img_rdata !== 32'd5) begin
      failures++;
      $display("FAIL img_rd5 got=%0d exp=5", a_img_rdata);
    end
    checks++;
    if (a_ker_rdata !== 32'd126) begin
      failures++;
      $display("FAIL ker_rd26 got=%0d exp=126", a_ker_rdata);
    end
    checks++;
    if (a_wgt_rdata !== 32'd203) begin
      failures++;
      $display("FAIL wgt_rd3 got=%0d exp=203", a_wgt_rdata);
    end
    checks++;
    if (a_core_opt !== 2'd2) begin
      failures++;
      $display("FAIL core_opt got=%0d exp=2", a_core_opt);
    end
    @(posedge clk); #1;
    checks++;
    if (a_core_start !== 1'b0) begin
      failures++;
      $display("FAIL core_start_width got=%0b exp=0", a_core_start);
    end
`ifdef SNN_IO_PROTO_CHK_EN
    checks++;
    if (a_proto_err !== 1'b0) begin
      failures++;
      $display("FAIL proto_clean got=%0b exp=0", a_proto_err);
    end
`endif
  endtask

  task automatic test_results_gapped();
    exp_words[0] = 32'h3F800000;
    exp_words[1] = 32'h40000000;
    exp_words[2] = 32'h40400000;
    exp_words[3] = 32'h40800000;
    run_results(2, 0, -1);
    checks++;
    if (sb_a.size() != 0) begin
      failures++;
      $display("FAIL sb_drained got=%0d exp=0", sb_a.size());
    end
  endtask

  task automatic test_emit_collision();
    int early;
    int starts;
    drive_frame(48, 500, 2'd1, early);
    checks++;
    if (a_core_start !== 1'b1) begin
      failures++;
      $display("FAIL frame2_start got=%0b exp=1", a_core_start);
    end
    for (int j = 0; j < 4; j++) exp_words[j] = 32'hA0 + 32'(j);
    run_results(0, 1, -1);
    starts = 0;
    repeat (4) begin
      if (a_core_start) starts++;
      @(posedge clk); #1;
    end
    checks++;
    if (starts != 0) begin
      failures++;
      $display("FAIL collision_no_start got=%0d exp=0", starts);
    end
    a_img_raddr = 6'd0;
    #1;
    checks++;
    if (a_img_rdata !== 32'd500 || a_core_opt !== 2'd1) begin
      failures++;
      $display("FAIL collision_no_capture got img0=%0d opt=%0d exp img0=500 opt=1", a_img_rdata, a_core_opt);
    end
`ifdef SNN_IO_PROTO_CHK_EN
    checks++;
    if (a_proto_err !== 1'b1) begin
      failures++;
      $display("FAIL proto_collision got=%0b exp=1", a_proto_err);
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    int early;
    drive_frame(48, 1000, 2'd3, early);
    for (int j = 0; j < 4; j++) exp_words[j] = 32'h11 + 32'(j);
    run_results(1, 0, 2);
    checks++;
    if (a_core_opt !== 2'd0 || a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_state got opt=%0d valid=%0b exp opt=0 valid=0", a_core_opt, a_out_valid);
    end
`ifdef SNN_IO_PROTO_CHK_EN
    checks++;
    if (a_proto_err !== 1'b0) begin
      failures++;
      $display("FAIL proto_after_reset got=%0b exp=0", a_proto_err);
    end
`endif
    drive_frame(48, 2000, 2'd0, early);
    a_img_raddr = 6'd5;
    #1;
    checks++;
    if (a_core_start !== 1'b1 || a_img_rdata !== 32'd2005) begin
      failures++;
      $display("FAIL post_reset_frame got start=%0b img5=%0d exp start=1 img5=2005", a_core_start, a_img_rdata);
    end
    for (int j = 0; j < 4; j++) exp_words[j] = 32'h5000 + 32'(j * 3);
    run_results(0, 0, -1);
  endtask

  task automatic test_short_frame();
    int early;
    int starts;
    drive_frame(30, 3000, 2'd1, early);
    starts = early;
    repeat (6) begin
      if (a_core_start) starts++;
      @(posedge clk); #1;
    end
    checks++;
    if (starts != 0) begin
      failures++;
      $display("FAIL short_no_start got=%0d exp=0", starts);
    end
`ifdef SNN_IO_PROTO_CHK_EN
    checks++;
    if (a_proto_err !== 1'b1) begin
      failures++;
      $display("FAIL proto_short got=%0b exp=1", a_proto_err);
    end
`endif
    drive_frame(48, 4000, 2'd2, early);
    checks++;
    if (early != 0 || a_core_start !== 1'b1) begin
      failures++;
      $display("FAIL after_short_start got early=%0d start=%0b exp early=0 start=1", early, a_core_start);
    end
    for (int j = 0; j < 4; j++) exp_words[j] = 32'h7700 + 32'(j);
    run_results(0, 0, -1);
  endtask

  task automatic test_small_back_to_back();
    logic [15:0] e;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) begin
        b_in_valid = 1'b1;
        b_img      = 16'(f * 16 + k + 1);
        b_ker      = 16'(f * 32 + k + 50);
        b_wgt      = 16'(f * 8 + k + 90);
        b_opt      = (k == 0) ? 2'(f + 1) : 2'd0;
        @(posedge clk); #1;
      end
      b_in_valid = 1'b0;
      b_img_raddr = 3'd3; b_ker_raddr = 3'd7; b_wgt_raddr = 1'b0;
      #1;
      checks++;
      if (b_core_start !== 1'b1 || b_core_opt !== 2'(f + 1)) begin
        failures++;
        $display("FAIL b_start f=%0d got start=%0b opt=%0d exp start=1 opt=%0d", f, b_core_start, b_core_opt, f + 1);
      end
      checks++;
      if (b_img_rdata !== 16'(f * 16 + 4) || b_ker_rdata !== 16'(f * 32 + 57) || b_wgt_rdata !== 16'(f * 8 + 90)) begin
        failures++;
        $display("FAIL b_bufs f=%0d got img3=%0d ker7=%0d wgt0=%0d exp %0d %0d %0d", f,
                 b_img_rdata, b_ker_rdata, b_wgt_rdata, f * 16 + 4, f * 32 + 57, f * 8 + 90);
      end
      b_res_valid = 1'b1;
      b_res_data  = 16'hBEE0 + 16'(f);
      sb_b.push_back(b_res_data);
      @(posedge clk); #1;
      b_res_valid = 1'b0;
      e = (sb_b.size() > 0) ? sb_b.pop_front() : 16'hxxxx;
      checks++;
      if (b_out_valid !== 1'b1 || b_out !== e) begin
        failures++;
        $display("FAIL b_out f=%0d got valid=%0b out=%h exp valid=1 out=%h", f, b_out_valid, b_out, e);
      end
      @(posedge clk); #1;
      checks++;
      if (b_out_valid !== 1'b0 || b_out !== 16'h0) begin
        failures++;
        $display("FAIL b_out_end f=%0d got valid=%0b out=%h exp valid=0 out=0", f, b_out_valid, b_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_results_gapped();
    test_emit_collision();
    test_reset_mid_burst();
    test_short_frame();
    test_small_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog");
  end

endmodule
